vx_csr_rmw_sched: RTL and testbench

//  Shares the single CSR read/write port of the CSR data block among NUM_REQS requesters (SFU CSR lanes).

---
 rtl/vx_csr_rmw_sched.sv | 132 +++++++++++++
 tb/tb_vx_csr_rmw_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_csr_rmw_sched.sv
// vx_csr_rmw_sched: round-robin scheduler that sequences one atomic CSR read-modify-write op at a time
// onto the shared CSR data port (IDLE -> READ -> WRITE -> RESP).
module vx_csr_rmw_sched #(
    parameter int NUM_REQS   = 4,
    parameter int ADDR_BITS  = 12,
    parameter int XLEN       = 32,
    parameter int NW_WIDTH   = 4,
    parameter int UUID_WIDTH = 44,
    localparam int IDX_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              req_valid,
    output logic [NUM_REQS-1:0]              req_ready,
    input  logic [NUM_REQS*2-1:0]            req_op,
    input  logic [NUM_REQS*NW_WIDTH-1:0]     req_wid,
    input  logic [NUM_REQS*ADDR_BITS-1:0]    req_addr,
    input  logic [NUM_REQS*UUID_WIDTH-1:0]   req_uuid,
    input  logic [NUM_REQS*XLEN-1:0]         req_data,
    output logic                             read_enable,
    output logic [UUID_WIDTH-1:0]            read_uuid,
    output logic [NW_WIDTH-1:0]              read_wid,
    output logic [ADDR_BITS-1:0]             read_addr,
    input  logic [XLEN-1:0]                  read_data_ro,
    input  logic [XLEN-1:0]                  read_data_rw,
    output logic                             write_enable,
    output logic [UUID_WIDTH-1:0]            write_uuid,
    output logic [NW_WIDTH-1:0]              write_wid,
    output logic [ADDR_BITS-1:0]             write_addr,
    output logic [XLEN-1:0]                  write_data,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [IDX_W-1:0]                 rsp_idx,
    output logic [UUID_WIDTH-1:0]            rsp_uuid,
    output logic [NW_WIDTH-1:0]              rsp_wid,
    output logic [XLEN-1:0]                  rsp_data,
    output logic                             rsp_illegal,
    output logic                             busy
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t state, state_n;
    logic [IDX_W-1:0]      rr_ptr, grant, cand, idx_r;
    logic                  grant_valid, take, ro, noop_mod;
    logic [1:0]            op_r;
    logic [NW_WIDTH-1:0]   wid_r;
    logic [ADDR_BITS-1:0]  addr_r;
    logic [UUID_WIDTH-1:0] uuid_r;
    logic [XLEN-1:0]       data_r, old_r;
    logic                  illegal_r;
    // Scan downwards so the requester closest to rr_ptr is the last (winning) match.
    always_comb begin
        grant_valid = 1'b0;
        grant = '0;
        cand = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQS);
            if (req_valid[cand]) begin
                grant_valid = 1'b1;
                grant = cand;
            end
        end
    end
    assign take = (state == IDLE) && grant_valid;
    always_comb begin
        req_ready = '0;
        if (take) req_ready[grant] = 1'b1;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = grant_valid ? READ : IDLE;
            READ:  state_n = WRITE;
            WRITE: state_n = RESP;
            RESP:  state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
        end else begin
            state <= state_n;
            if (take) rr_ptr <= IDX_W'((int'(grant) + 1) % NUM_REQS);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r <= '0;
            wid_r <= '0;
            addr_r <= '0;
            uuid_r <= '0;
            data_r <= '0;
            idx_r <= '0;
            old_r <= '0;
            illegal_r <= 1'b0;
        end else begin
            if (take) begin
                op_r <= req_op[int'(grant)*2 +: 2];
                wid_r <= req_wid[int'(grant)*NW_WIDTH +: NW_WIDTH];
                addr_r <= req_addr[int'(grant)*ADDR_BITS +: ADDR_BITS];
                uuid_r <= req_uuid[int'(grant)*UUID_WIDTH +: UUID_WIDTH];
                data_r <= req_data[int'(grant)*XLEN +: XLEN];
                idx_r <= grant;
                illegal_r <= 1'b0;
            end
            if (state == READ) old_r <= read_data_ro | read_data_rw;
            if (state == WRITE) illegal_r <= ro && (op_r != 2'b11);
        end
    end
    // Top two address bits 2'b11 mark a read-only CSR; set/clear with a zero mask is not a write.
    assign ro = addr_r[ADDR_BITS-1 -: 2] == 2'b11;
    assign noop_mod = (op_r == 2'b01 || op_r == 2'b10) && (data_r == '0);
    assign write_data = (op_r == 2'b00) ? data_r :
                        (op_r == 2'b01) ? (old_r | data_r) :
                        (op_r == 2'b10) ? (old_r & ~data_r) : old_r;
    assign write_enable = (state == WRITE) && (op_r != 2'b11) && !noop_mod && !ro;
    assign read_enable = state == READ;
    assign read_uuid = uuid_r;
    assign read_wid = wid_r;
    assign read_addr = addr_r;
    assign write_uuid = uuid_r;
    assign write_wid = wid_r;
    assign write_addr = addr_r;
    assign rsp_valid = state == RESP;
    assign rsp_idx = idx_r;
    assign rsp_uuid = uuid_r;
    assign rsp_wid = wid_r;
    assign rsp_data = old_r;
    assign rsp_illegal = illegal_r;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_vx_csr_rmw_sched.sv
// tb_vx_csr_rmw_sched: directed and randomized checks of the CSR RMW scheduler against a
// transaction-level model (CSR memory, round-robin pointer, fixed op latency).
module tb_vx_csr_rmw_sched;
    localparam int N = 4, AB = 12, XL = 32, NW = 4, UW = 44;
    logic clk = 1'b0, reset = 1'b1;
    logic [N-1:0] req_valid, req_ready;
    logic [N*2-1:0] req_op;
    logic [N*NW-1:0] req_wid;
    logic [N*AB-1:0] req_addr;
    logic [N*UW-1:0] req_uuid;
    logic [N*XL-1:0] req_data;
    logic read_enable, write_enable, rsp_valid, rsp_ready, rsp_illegal, busy;
    logic [UW-1:0] read_uuid, write_uuid, rsp_uuid;
    logic [NW-1:0] read_wid, write_wid, rsp_wid;
    logic [AB-1:0] read_addr, write_addr;
    logic [XL-1:0] read_data_ro, read_data_rw, write_data, rsp_data;
    logic [1:0] rsp_idx;
    logic [XL-1:0] mem [0:4095];
    bit pend [N];
    logic [1:0] p_op [N];
    logic [NW-1:0] p_wid [N];
    logic [UW-1:0] p_uuid [N];
    logic [AB-1:0] p_addr [N];
    logic [XL-1:0] p_data [N];
    int vectors = 0, errors = 0;

    vx_csr_rmw_sched #(.NUM_REQS(N), .ADDR_BITS(AB), .XLEN(XL), .NW_WIDTH(NW), .UUID_WIDTH(UW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_wid(req_wid), .req_addr(req_addr), .req_uuid(req_uuid), .req_data(req_data),
        .read_enable(read_enable), .read_uuid(read_uuid), .read_wid(read_wid), .read_addr(read_addr),
        .read_data_ro(read_data_ro), .read_data_rw(read_data_rw), .write_enable(write_enable),
        .write_uuid(write_uuid), .write_wid(write_wid), .write_addr(write_addr), .write_data(write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_idx(rsp_idx), .rsp_uuid(rsp_uuid),
        .rsp_wid(rsp_wid), .rsp_data(rsp_data), .rsp_illegal(rsp_illegal), .busy(busy)
    );

    always #5 clk = ~clk;
    // CSR data block: read-only space answers on the ro port, everything else on the rw port.
    assign read_data_ro = (read_addr[11:10] == 2'b11) ? mem[read_addr] : '0;
    assign read_data_rw = (read_addr[11:10] != 2'b11) ? mem[read_addr] : '0;

    function automatic logic [XL-1:0] f_new(logic [1:0] o, logic [XL-1:0] old, logic [XL-1:0] d);
        return o == 2'd0 ? d : o == 2'd1 ? (old | d) : o == 2'd2 ? (old & ~d) : old;
    endfunction
    function automatic bit f_we(logic [1:0] o, logic [AB-1:0] a, logic [XL-1:0] d);
        return o != 2'd3 && !((o == 2'd1 || o == 2'd2) && d == 0) && a[11:10] != 2'b11;
    endfunction
    function automatic bit f_ill(logic [1:0] o, logic [AB-1:0] a);
        return o != 2'd3 && a[11:10] == 2'b11;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_op[i*2 +: 2] = p_op[i];
            req_wid[i*NW +: NW] = p_wid[i];
            req_uuid[i*UW +: UW] = p_uuid[i];
            req_addr[i*AB +: AB] = p_addr[i];
            req_data[i*XL +: XL] = p_data[i];
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            p_op[i] = 2'd3;
            p_wid[i] = NW'(i);
            p_uuid[i] = UW'(i + 100);
            p_addr[i] = 12'h340;
            p_data[i] = '0;
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_reqs();
        rsp_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        vectors++; if ({busy, read_enable, write_enable, rsp_valid, rsp_illegal, req_ready} !== 9'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 0", {busy, read_enable, write_enable, rsp_valid, rsp_illegal, req_ready});
        end
        vectors++; if ({rsp_data, write_data, rsp_idx} !== '0) begin
            errors++; $display("FAIL reset_data: got %h/%h/%0d exp 0", rsp_data, write_data, rsp_idx);
        end
        reset = 1'b0;
    endtask

    task automatic test_rmw();
        int ti [6] = '{0, 1, 1, 2, 3, 0};
        logic [1:0] to [6] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3};
        logic [11:0] ta [6] = '{12'h340, 12'h340, 12'h340, 12'h001, 12'hF11, 12'h340};
        logic [31:0] td [6] = '{32'hA5, 32'h0F, 32'hF0, 32'h0, 32'h5, 32'h1234};
        logic [31:0] tp [6] = '{32'h11, 32'hF0, 32'h0, 32'h1F, 32'hCAFE, 32'h0};
        bit tl [6] = '{1, 1, 0, 1, 1, 0};
        logic [XL-1:0] old, nv;
        logic [N-1:0] er;
        bit we;
        clear_reqs();
        do_reset();
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            if (tl[e]) mem[ta[e]] = tp[e];
            old = mem[ta[e]];
            nv = f_new(to[e], old, td[e]);
            we = f_we(to[e], ta[e], td[e]);
            er = N'(1) << ti[e];
            pend[ti[e]] = 1;
            p_op[ti[e]] = to[e];
            p_addr[ti[e]] = ta[e];
            p_data[ti[e]] = td[e];
            drive();
            #1;
            vectors++; if (req_ready !== er) begin errors++; $display("FAIL rmw%0d ready: got %b exp %b", e, req_ready, er); end
            @(negedge clk);
            pend[ti[e]] = 0;
            drive();
            #1;
            vectors++; if ({read_enable, write_enable} !== 2'b10 || read_addr !== ta[e]) begin
                errors++; $display("FAIL rmw%0d read: got re=%b we=%b addr=%h exp 1/0/%h", e, read_enable, write_enable, read_addr, ta[e]);
            end
            @(negedge clk);
            #1;
            vectors++; if (write_enable !== we || read_enable !== 1'b0) begin
                errors++; $display("FAIL rmw%0d write_en: got %b exp %b", e, write_enable, we);
            end
            if (to[e] != 2'd3) begin
                vectors++; if (write_data !== nv) begin errors++; $display("FAIL rmw%0d write_data: got %h exp %h", e, write_data, nv); end
            end
            if (we) mem[ta[e]] = nv;
            @(negedge clk);
            #1;
            vectors++; if (rsp_valid !== 1'b1 || rsp_data !== old || rsp_idx !== 2'(ti[e]) || rsp_illegal !== f_ill(to[e], ta[e])) begin
                errors++; $display("FAIL rmw%0d rsp: got v=%b d=%h i=%0d ill=%b exp 1/%h/%0d/%b",
                                   e, rsp_valid, rsp_data, rsp_idx, rsp_illegal, old, ti[e], f_ill(to[e], ta[e]));
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_g = 0, last = -100, grants = 0;
        logic [N-1:0] er;
        clear_reqs();
        for (int i = 0; i < N; i++) pend[i] = 1;
        drive();
        do_reset();
        for (int cyc = 0; cyc < 40 && grants < 5; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (req_ready !== '0) begin
                er = N'(1) << exp_g;
                vectors++; if (req_ready !== er) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", grants, req_ready, er); end
                vectors++; if (cyc - last < 4) begin errors++; $display("FAIL rr_gap%0d: got %0d exp >=4", grants, cyc - last); end
                last = cyc;
                exp_g = (exp_g + 1) % N;
                grants++;
            end
        end
        vectors++; if (grants != 5) begin errors++; $display("FAIL rr_count: got %0d exp 5", grants); end
        clear_reqs();
    endtask

    task automatic test_stall();
        clear_reqs();
        do_reset();
        rsp_ready = 1'b0;
        mem[12'h340] = 32'h33;
        @(negedge clk);
        pend[2] = 1;
        p_op[2] = 2'd0;
        p_data[2] = 32'h77;
        drive();
        #1;
        vectors++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_grant: got %b exp 0100", req_ready); end
        @(negedge clk);
        pend[2] = 0;
        pend[0] = 1;
        pend[1] = 1;
        drive();
        @(negedge clk);
        mem[12'h340] = 32'h77;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h33 || rsp_idx !== 2'd2 || req_ready !== '0 || busy !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d: got v=%b d=%h i=%0d rdy=%b busy=%b exp 1/33/2/0000/1",
                                   k, rsp_valid, rsp_data, rsp_idx, req_ready, busy);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        vectors++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release: got rdy=%b v=%b exp 0001/0", req_ready, rsp_valid);
        end
        @(negedge clk);
        clear_reqs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        clear_reqs();
        do_reset();
        mem[12'h340] = 32'h44;
        @(negedge clk);
        pend[1] = 1;
        p_op[1] = 2'd0;
        p_data[1] = 32'h99;
        drive();
        @(negedge clk);
        pend[1] = 0;
        drive();
        @(negedge clk);
        #1;
        vectors++; if (write_enable !== 1'b1) begin errors++; $display("FAIL midrst_pre: got we=%b exp 1", write_enable); end
        reset = 1'b1;
        #1;
        vectors++; if ({write_enable, rsp_valid, busy} !== 3'b000) begin
            errors++; $display("FAIL midrst_drop: got we/v/busy=%b exp 000", {write_enable, rsp_valid, busy});
        end
        for (int i = 0; i < N; i++) pend[i] = 1;
        drive();
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_first: got %b exp 0001", req_ready); end
        @(negedge clk);
        clear_reqs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [11:0] pool [5] = '{12'h340, 12'h001, 12'hF11, 12'hC00, 12'h300};
        int ptr_m = 0, t = 0, g, j, cur = 0, ops = 0;
        bit busy_m = 0;
        logic [1:0] c_op = '0;
        logic [AB-1:0] c_addr = '0;
        logic [XL-1:0] c_data = '0, c_old = '0;
        logic [NW-1:0] c_wid = '0;
        logic [UW-1:0] c_uuid = '0;
        logic [N-1:0] er;
        clear_reqs();
        for (int i = 0; i < 5; i++) mem[pool[i]] = $urandom;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1;
                    p_op[i] = 2'($urandom_range(0, 3));
                    p_addr[i] = pool[$urandom_range(0, 4)];
                    p_data[i] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
                    p_wid[i] = NW'($urandom);
                    p_uuid[i] = UW'({$urandom, $urandom});
                end else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 0;
            end
            rsp_ready = $urandom_range(0, 2) != 0;
            drive();
            #1;
            if (busy_m) t++;
            if (!busy_m) begin
                g = -1;
                for (int k = 0; k < N; k++) begin
                    j = (ptr_m + k) % N;
                    if (pend[j] && g < 0) g = j;
                end
                er = (g >= 0) ? (N'(1) << g) : '0;
                vectors++; if (req_ready !== er || busy !== 1'b0 || rsp_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd_idle@%0d: got rdy=%b busy=%b v=%b exp %b/0/0", cyc, req_ready, busy, rsp_valid, er);
                end
                if (g >= 0) begin
                    cur = g; c_op = p_op[g]; c_addr = p_addr[g]; c_data = p_data[g];
                    c_wid = p_wid[g]; c_uuid = p_uuid[g]; c_old = mem[c_addr];
                    busy_m = 1; t = 0; ptr_m = (g + 1) % N; pend[g] = 0; ops++;
                end
            end else if (t == 1) begin
                vectors++; if ({read_enable, write_enable} !== 2'b10 || req_ready !== '0 || read_addr !== c_addr ||
                               read_wid !== c_wid || read_uuid !== c_uuid) begin
                    errors++; $display("FAIL rnd_read@%0d: got re=%b we=%b addr=%h exp 1/0/%h", cyc, read_enable, write_enable, read_addr, c_addr);
                end
            end else if (t == 2) begin
                vectors++; if (write_enable !== f_we(c_op, c_addr, c_data) || read_enable !== 1'b0 || write_addr !== c_addr) begin
                    errors++; $display("FAIL rnd_we@%0d: got %b exp %b", cyc, write_enable, f_we(c_op, c_addr, c_data));
                end
                if (c_op != 2'd3) begin
                    vectors++; if (write_data !== f_new(c_op, c_old, c_data)) begin
                        errors++; $display("FAIL rnd_wdata@%0d: got %h exp %h", cyc, write_data, f_new(c_op, c_old, c_data));
                    end
                end
                if (f_we(c_op, c_addr, c_data)) mem[c_addr] = f_new(c_op, c_old, c_data);
            end else begin
                vectors++; if (rsp_valid !== 1'b1 || rsp_data !== c_old || rsp_idx !== 2'(cur) || rsp_illegal !== f_ill(c_op, c_addr) ||
                               rsp_wid !== c_wid || rsp_uuid !== c_uuid || req_ready !== '0 || write_enable !== 1'b0) begin
                    errors++; $display("FAIL rnd_rsp@%0d: got v=%b d=%h i=%0d ill=%b exp 1/%h/%0d/%b",
                                       cyc, rsp_valid, rsp_data, rsp_idx, rsp_illegal, c_old, cur, f_ill(c_op, c_addr));
                end
                if (rsp_ready) busy_m = 0;
            end
        end
        vectors++; if (ops < 50) begin errors++; $display("FAIL rnd_progress: got %0d ops exp >=50", ops); end
        clear_reqs();
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_rmw();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
